// File: rtl/arm_mem_pkg.sv
// Shared definitions for the single-port SRAM arbiter: state encoding and defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arm_mem_pkg;

  localparam int unsigned DEF_WAIT_CYCLES = 4;
  localparam int unsigned DEF_SRAM_AW     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_M_ACC  = 2'd1,
    ST_I_ACC  = 2'd2,
    ST_M_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing one SRAM access; o_zero marks the last access cycle.
// Latency: load takes effect on the next edge; o_zero is combinational from the count.
// Backpressure: none; i_load has priority over i_dec, and the count holds at zero.
// Ports: clk/rst (async active-low), i_load/i_load_val, i_dec, o_zero.
module sram_wait_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM between instruction fetch and load/store; drives pipeline freezes.
// Latency: MEM access W+1 cycles to mem_ready; IF miss W+1 cycles to if_ready; IF hit 0.
// Backpressure: freeze_all stalls all stages during a MEM op; freeze_if stalls PC/IF-ID on a miss.
// Ports: IF side (if_req/if_addr -> if_rdata/if_ready), MEM side (mem_rd_en/mem_wr_en/
//        mem_addr/mem_wdata -> mem_rdata/mem_ready), freezes, SRAM pins (sram_*).
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic [31:0]        if_rdata,
  output logic               if_ready,
  input  logic               mem_rd_en,
  input  logic               mem_wr_en,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               mem_ready,
  output logic               freeze_all,
  output logic               freeze_if,
  output logic               sram_cs_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  arb_state_t r_state, w_state_nxt;

  logic               r_sram_cs_n, r_sram_oe_n, r_sram_we_n;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [31:0]        r_sram_wdata;
  logic               r_is_wr;
  logic [31:0]        r_mem_rdata;
  logic [31:0]        r_fetch_addr;
  logic               r_buf_valid;
  logic [31:0]        r_buf_addr;
  logic [31:0]        r_buf_data;

  logic w_mem_req, w_if_ready, w_mem_ready, w_freeze_all;
  logic w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic w_grant_mem, w_grant_if, w_acc_end, w_buf_load;
  logic w_unused_addr;

  // Byte-lane bits and bits above the SRAM word range are not part of the SRAM address.
  assign w_unused_addr = ^{mem_addr[31:SRAM_AW+2], mem_addr[1:0]};

  assign w_mem_req    = mem_rd_en | mem_wr_en;
  assign w_if_ready   = r_buf_valid & (r_buf_addr == if_addr);
  assign w_mem_ready  = (r_state == ST_M_DONE);
  assign w_freeze_all = w_mem_req & ~w_mem_ready;

  sram_wait_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_W'(WAIT_CYCLES - 1)),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // MEM is checked before IF so a load/store always wins arbitration in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_grant_mem = 1'b0;
    w_grant_if  = 1'b0;
    w_acc_end   = 1'b0;
    w_buf_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_req) begin
          w_state_nxt = ST_M_ACC;
          w_grant_mem = 1'b1;
          w_cnt_load  = 1'b1;
        end else if (if_req && !w_if_ready) begin
          w_state_nxt = ST_I_ACC;
          w_grant_if  = 1'b1;
          w_cnt_load  = 1'b1;
        end
      end
      ST_M_ACC: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_M_DONE;
          w_acc_end   = 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_I_ACC: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
          w_acc_end   = 1'b1;
          w_buf_load  = 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_M_DONE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // SRAM pins are registered at grant and held until the last access cycle, so
  // address, data and strobes stay stable for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sram_cs_n  <= 1'b1;
      r_sram_oe_n  <= 1'b1;
      r_sram_we_n  <= 1'b1;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_is_wr      <= 1'b0;
      r_mem_rdata  <= '0;
      r_fetch_addr <= '0;
    end else if (w_grant_mem) begin
      r_sram_cs_n  <= 1'b0;
      r_sram_oe_n  <= mem_wr_en;
      r_sram_we_n  <= ~mem_wr_en;
      r_sram_addr  <= mem_addr[SRAM_AW+1:2];
      r_sram_wdata <= mem_wdata;
      r_is_wr      <= mem_wr_en;
    end else if (w_grant_if) begin
      r_sram_cs_n  <= 1'b0;
      r_sram_oe_n  <= 1'b0;
      r_sram_we_n  <= 1'b1;
      r_sram_addr  <= if_addr[SRAM_AW+1:2];
      r_fetch_addr <= if_addr;
    end else if (w_acc_end) begin
      r_sram_cs_n <= 1'b1;
      r_sram_oe_n <= 1'b1;
      r_sram_we_n <= 1'b1;
      if ((r_state == ST_M_ACC) && !r_is_wr) r_mem_rdata <= sram_rdata;
    end
  end

  // Fetch buffer: tagged with the address the fetch was issued for, so a redirect
  // during the fetch simply misses and triggers a refetch. A fill wins over a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
    end else if (w_buf_load) begin
      r_buf_valid <= 1'b1;
      r_buf_addr  <= r_fetch_addr;
      r_buf_data  <= sram_rdata;
    end else if (if_req && w_if_ready && !w_freeze_all) begin
      r_buf_valid <= 1'b0;
    end
  end

  assign if_ready   = w_if_ready;
  assign if_rdata   = r_buf_data;
  assign mem_rdata  = r_mem_rdata;
  assign mem_ready  = w_mem_ready;
  assign freeze_all = w_freeze_all;
  assign freeze_if  = w_freeze_all | (if_req & ~w_if_ready);
  assign sram_cs_n  = r_sram_cs_n;
  assign sram_oe_n  = r_sram_oe_n;
  assign sram_we_n  = r_sram_we_n;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-timeline reference model plus
// directed scenarios with literal expectations, followed by randomized traffic.
// The bench also plays the SRAM device (64-word array, combinational read).
module tb_mem_port_arbiter;

  localparam int W  = 4;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic          mem_rd_en = 1'b0;
  logic          mem_wr_en = 1'b0;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [31:0]   if_rdata, mem_rdata, sram_wdata, sram_rdata;
  logic          if_ready, mem_ready, freeze_all, freeze_if;
  logic          sram_cs_n, sram_oe_n, sram_we_n;
  logic [AW-1:0] sram_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .freeze_all(freeze_all), .freeze_if(freeze_if),
    .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // ---------------- SRAM device ----------------
  logic [31:0] dev_mem [64];
  assign sram_rdata = (!sram_cs_n && !sram_oe_n) ? dev_mem[sram_addr[5:0]] : 32'h0BAD_F00D;
  always @(posedge clk) begin
    if (!sram_cs_n && !sram_we_n) dev_mem[sram_addr[5:0]] = sram_wdata;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A transaction is described by its kind and its age: age 1..W are the SRAM
  // access cycles, age W+1 is the completion cycle of a load/store.
  localparam int OP_NONE = 0, OP_RD = 1, OP_WR = 2, OP_IF = 3;
  int          m_op;
  int          m_age;
  logic [15:0] m_word;
  logic [31:0] m_wdat, m_faddr, m_rdata;
  logic        m_bv;
  logic [31:0] m_ba, m_bd;
  logic [31:0] model_mem [64];

  function automatic logic f_access();
    return (m_op != OP_NONE) && (m_age >= 1) && (m_age <= W);
  endfunction
  function automatic logic f_mem_ready();
    return ((m_op == OP_RD) || (m_op == OP_WR)) && (m_age == W + 1);
  endfunction
  function automatic logic f_if_ready();
    return m_bv && (m_ba == if_addr);
  endfunction
  function automatic logic f_freeze_all();
    return (mem_rd_en | mem_wr_en) & ~f_mem_ready();
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_op = OP_NONE; m_age = 0; m_word = '0; m_wdat = '0; m_faddr = '0;
      m_rdata = '0; m_bv = 1'b0; m_ba = '0; m_bd = '0;
    end else begin
      logic rdy, clr;
      rdy = f_if_ready();
      clr = if_req & rdy & ~f_freeze_all();
      if (m_op == OP_NONE) begin
        if (mem_rd_en | mem_wr_en) begin
          m_op = mem_wr_en ? OP_WR : OP_RD;
          m_age = 1; m_word = mem_addr[17:2]; m_wdat = mem_wdata;
        end else if (if_req && !rdy) begin
          m_op = OP_IF; m_age = 1; m_word = if_addr[17:2]; m_faddr = if_addr;
        end
      end else if (m_age == W) begin
        if (m_op == OP_RD) begin
          m_rdata = model_mem[m_word[5:0]]; m_age = m_age + 1;
        end else if (m_op == OP_WR) begin
          model_mem[m_word[5:0]] = m_wdat; m_age = m_age + 1;
        end else begin
          m_bv = 1'b1; m_ba = m_faddr; m_bd = model_mem[m_word[5:0]];
          m_op = OP_NONE; clr = 1'b0;
        end
      end else if (m_age == W + 1) begin
        m_op = OP_NONE;
      end else begin
        m_age = m_age + 1;
      end
      if (clr) m_bv = 1'b0;
    end
  end

  // One compare process: every cycle, mid-cycle, against the model.
  logic e_acc, e_rdy;
  always @(negedge clk) begin
    if (chk_en) begin
      e_acc = f_access();
      e_rdy = f_if_ready();
      chk("cs_n", {31'd0, sram_cs_n}, {31'd0, ~e_acc});
      chk("oe_n", {31'd0, sram_oe_n}, {31'd0, ~(e_acc && m_op != OP_WR)});
      chk("we_n", {31'd0, sram_we_n}, {31'd0, ~(e_acc && m_op == OP_WR)});
      chk("mem_ready", {31'd0, mem_ready}, {31'd0, f_mem_ready()});
      chk("if_ready", {31'd0, if_ready}, {31'd0, e_rdy});
      chk("freeze_all", {31'd0, freeze_all}, {31'd0, f_freeze_all()});
      chk("freeze_if", {31'd0, freeze_if}, {31'd0, f_freeze_all() | (if_req & ~e_rdy)});
      chk("mem_rdata", mem_rdata, m_rdata);
      if (e_acc) chk("sram_addr", {16'd0, sram_addr}, {16'd0, m_word});
      if (e_acc && m_op == OP_WR) chk("sram_wdata", sram_wdata, m_wdat);
      if (e_rdy) chk("if_rdata", if_rdata, m_bd);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_mem(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int fz, output int strobe,
                        output logic [15:0] saddr, output logic [31:0] rdata);
    mem_rd_en = ~wr; mem_wr_en = wr; mem_addr = a; mem_wdata = d;
    lat = -1; fz = 0; strobe = 0; saddr = '0; rdata = '0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (freeze_all) fz++;
      if (!sram_cs_n && (wr ? !sram_we_n : !sram_oe_n)) begin
        strobe++; saddr = sram_addr;
      end
      if (mem_ready) begin
        lat = n; rdata = mem_rdata;
        break;
      end
      next_cycle();
    end
    next_cycle();
    mem_rd_en = 1'b0; mem_wr_en = 1'b0;
  endtask

  int          lat, fz, strobe, first, cnt;
  logic [15:0] saddr;
  logic [31:0] rdata;

  initial begin
    #1 rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      dev_mem[i] = $urandom; model_mem[i] = dev_mem[i];
    end
    dev_mem[4]  = 32'hDEADBEEF; model_mem[4]  = 32'hDEADBEEF;
    dev_mem[8]  = 32'hCAFE0008; model_mem[8]  = 32'hCAFE0008;
    dev_mem[16] = 32'hCAFE0010; model_mem[16] = 32'hCAFE0010;
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset_cs_n", {31'd0, sram_cs_n}, 32'd1);
    chk("reset_mem_rdata", mem_rdata, 32'd0);
    next_cycle();
    rst = 1'b1;
    next_cycle(); next_cycle();

    // Reset in the second M_ACC cycle, then the held load reissues.
    mem_rd_en = 1'b1; mem_addr = 32'h10;
    next_cycle(); next_cycle();
    rst = 1'b0;
    #1;
    chk("rst_mid_cs_n", {31'd0, sram_cs_n}, 32'd1);
    chk("rst_mid_oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("rst_mid_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_mid_mem_ready", {31'd0, mem_ready}, 32'd0);
    next_cycle(); next_cycle();
    rst = 1'b1;
    lat = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (mem_ready) begin
        lat = n; break;
      end
      next_cycle();
    end
    chk("rst_reissue_latency", lat, 32'd5);
    chk("rst_reissue_rdata", mem_rdata, 32'hDEADBEEF);
    next_cycle();
    mem_rd_en = 1'b0;
    next_cycle(); next_cycle();

    // Isolated load of word 4.
    do_mem(1'b0, 32'h10, 32'h0, lat, fz, strobe, saddr, rdata);
    chk("load_latency", lat, 32'd5);
    chk("load_freeze_cycles", fz, 32'd5);
    chk("load_oe_cycles", strobe, 32'd4);
    chk("load_sram_addr", {16'd0, saddr}, 32'd4);
    chk("load_rdata", rdata, 32'hDEADBEEF);
    next_cycle();

    // Store then load back.
    do_mem(1'b1, 32'h8, 32'h12345678, lat, fz, strobe, saddr, rdata);
    chk("store_latency", lat, 32'd5);
    chk("store_we_cycles", strobe, 32'd4);
    chk("store_sram_addr", {16'd0, saddr}, 32'd2);
    next_cycle();
    do_mem(1'b0, 32'h8, 32'h0, lat, fz, strobe, saddr, rdata);
    chk("store_readback", rdata, 32'h12345678);
    next_cycle(); next_cycle();

    // Simultaneous IF miss and load: MEM first, fetch after the turnaround cycle.
    first = -1; cnt = 0;
    for (int n = 0; n < 14; n++) begin
      if (n == 0) begin
        if_req = 1'b1; if_addr = 32'h20; mem_rd_en = 1'b1; mem_addr = 32'h10;
      end
      if (n == 6) mem_rd_en = 1'b0;
      if (n == 12) if_req = 1'b0;
      @(negedge clk);
      if (n <= 10 && freeze_if) cnt++;
      if (if_ready && first < 0) first = n;
      if (n == 11) chk("simul_if_rdata", if_rdata, 32'hCAFE0008);
      next_cycle();
    end
    chk("simul_if_ready_cycle", first, 32'd11);
    chk("simul_freeze_if_cycles", cnt, 32'd11);
    next_cycle();

    // Fetch completes while a MEM op freezes the pipeline; buffer holds.
    cnt = 0;
    for (int n = 0; n < 13; n++) begin
      if (n == 0) begin
        if_req = 1'b1; if_addr = 32'h40;
      end
      if (n == 2) begin
        mem_rd_en = 1'b1; mem_addr = 32'h10;
      end
      if (n == 11) begin
        mem_rd_en = 1'b0; if_req = 1'b0;
      end
      @(negedge clk);
      if (n >= 5 && n <= 10 && if_ready) cnt++;
      if (n == 5) chk("frz_if_rdata", if_rdata, 32'hCAFE0010);
      if (n == 9) chk("frz_freeze_all", {31'd0, freeze_all}, 32'd1);
      if (n == 11) chk("frz_buf_cleared", {31'd0, if_ready}, 32'd0);
      next_cycle();
    end
    chk("frz_if_ready_held", cnt, 32'd6);
    next_cycle();

    // Branch redirect mid-fetch: stale fill misses, refetch of 0x40.
    for (int n = 0; n < 13; n++) begin
      if (n == 0) begin
        if_req = 1'b1; if_addr = 32'h20;
      end
      if (n == 2) if_addr = 32'h40;
      if (n == 11) if_req = 1'b0;
      @(negedge clk);
      if (n == 5) chk("redir_stale_miss", {31'd0, if_ready}, 32'd0);
      if (n == 7) chk("redir_sram_addr", {16'd0, sram_addr}, 32'h10);
      if (n == 10) begin
        chk("redir_if_ready", {31'd0, if_ready}, 32'd1);
        chk("redir_if_rdata", if_rdata, 32'hCAFE0010);
      end
      next_cycle();
    end
    next_cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      mem_wr_en = ($urandom_range(0, 7) == 0);
      mem_rd_en = ($urandom_range(0, 4) == 0);
      mem_addr  = {24'd0, 8'($urandom)};
      mem_wdata = $urandom;
      if_req    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) if_addr = {26'd0, 4'($urandom), 2'b00};
      next_cycle();
    end
    if_req = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    repeat (12) next_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
